// File: rtl/led_pwm_fader.sv
`timescale 1ns/1ps
// led_pwm_fader
//
// Takes the LED pattern written by software to the LED PIO and drives the
// board LED pins with per-channel PWM. When fading is enabled, each channel's
// brightness moves linearly toward full-on or full-off, one step per PWM
// frame. LED changes therefore fade in and out instead of switching at once.
// When fading is disabled, the pattern goes straight through to the pins.
//
// Parameters
//   CHANNELS  : number of LED channels (one in_port bit per channel)
//   TICK_DIV  : clk cycles per PWM step (>= 1; 1 = a step every cycle)
//   FADE_STEP : brightness change applied per PWM frame (1..255)
//
// Ports
//   clk      : system clock, single domain shared with the PIO
//   reset_n  : asynchronous active-low reset
//   in_port  : target pattern, 1 = on, 0 = off
//   fade_en  : 1 = fading PWM, 0 = direct bypass
//   led_out  : registered LED drive, active high
//   busy     : registered, high while any level differs from its target
//
// Frame structure: a prescaler produces one tick every TICK_DIV cycles. The
// 8-bit PWM counter advances on each tick, so a frame is 256*TICK_DIV cycles.
// Levels move only on the last tick of a frame. This keeps the duty cycle
// constant within a frame.

module led_pwm_fader #(
    parameter int CHANNELS  = 8,
    parameter int TICK_DIV  = 196,
    parameter int FADE_STEP = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] in_port,
    input  logic                fade_en,
    output logic [CHANNELS-1:0] led_out,
    output logic                busy
);

    // TICK_DIV = 1 would give a zero-width prescaler, so keep at least one bit.
    // In that case the counter stays at 0 and ticks every cycle.
    localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [8:0]     STEP9      = 9'(FADE_STEP);
    localparam logic [7:0]     STEP8      = 8'(FADE_STEP);

    logic [CHANNELS-1:0] in_d,      in_q;
    logic [PW-1:0]       presc_d,   presc_q;
    logic [7:0]          pwm_cnt_d, pwm_cnt_q;
    logic [7:0]          level_d    [CHANNELS];
    logic [7:0]          level_q    [CHANNELS];
    logic [CHANNELS-1:0] led_out_d, led_out_q;
    logic                busy_d,    busy_q;

    logic                tick;
    logic                frame_end;
    logic [7:0]          target     [CHANNELS];
    logic [8:0]          sum9       [CHANNELS];
    logic [7:0]          up_val     [CHANNELS];
    logic [7:0]          dn_val     [CHANNELS];
    logic [CHANNELS-1:0] diff;

    // ------------------------------------------------------------------
    // Input register, prescaler and PWM counter
    // ------------------------------------------------------------------
    always_comb begin
        in_d      = in_port;
        tick      = (presc_q == PRESC_LAST);
        presc_d   = tick ? '0 : presc_q + PW'(1);
        pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        frame_end = tick && (pwm_cnt_q == 8'hFF);
    end

    // ------------------------------------------------------------------
    // Per-channel level update, output compare and mismatch detect
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            target[i] = in_q[i] ? 8'hFF : 8'h00;

            // The upward step is computed 9 bits wide so the carry can
            // saturate it at 255. The downward step is clamped at 0 rather
            // than wrapping.
            sum9[i]   = {1'b0, level_q[i]} + STEP9;
            up_val[i] = sum9[i][8] ? 8'hFF : sum9[i][7:0];
            dn_val[i] = (level_q[i] < STEP8) ? 8'h00 : level_q[i] - STEP8;

            level_d[i] = level_q[i];
            if (!fade_en) begin
                // Snapping to the target in bypass lets a later re-enable
                // resume without a visible jump.
                level_d[i] = target[i];
            end else if (frame_end && (level_q[i] != target[i])) begin
                level_d[i] = in_q[i] ? up_val[i] : dn_val[i];
            end

            // Level 255 is forced on so that full brightness has no
            // one-step gap per frame.
            if (fade_en) begin
                led_out_d[i] = (level_q[i] == 8'hFF) || (level_q[i] > pwm_cnt_q);
            end else begin
                led_out_d[i] = in_q[i];
            end

            diff[i] = (level_q[i] != target[i]);
        end

        busy_d = fade_en && (|diff);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q      <= '0;
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            led_out_q <= '0;
            busy_q    <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                level_q[i] <= 8'h00;
            end
        end else begin
            in_q      <= in_d;
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_out_q <= led_out_d;
            busy_q    <= busy_d;
            for (int i = 0; i < CHANNELS; i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end

    assign led_out = led_out_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
`timescale 1ns/1ps
// Testbench for led_pwm_fader with TICK_DIV=2 and FADE_STEP=64, which gives a
// 512-cycle frame. cyc counts rising edges since the last reset release.
// After rising edge k, and until the next one, cyc == k. Level steps land on
// edges 512*m after release.

module tb_led_pwm_fader;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_port;
    logic       fade_en;
    logic [7:0] led_out;
    logic       busy;

    int n_checks = 0;
    int n_err    = 0;
    int cyc;

    typedef struct {
        logic [7:0] in_v;
        logic       fade;
        logic [7:0] exp_d1;
        logic [7:0] exp_d2;
        logic       exp_busy;
    } vec_t;

    vec_t vecs [5];

    led_pwm_fader #(
        .CHANNELS (8),
        .TICK_DIV (2),
        .FADE_STEP(64)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .in_port(in_port),
        .fade_en(fade_en),
        .led_out(led_out),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cyc=%0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic do_reset(input logic [7:0] v);
        @(negedge clk);
        reset_n = 1'b0;
        in_port = v;
        repeat (2) @(negedge clk);
        check("rst_led", {24'd0, led_out}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_level0", {24'd0, dut.level_q[0]}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int exp_lv [5];
        int exp_cnt [5];
        int cnt;
        int frame;
        int f0;
        int bad_led;
        int bad_busy;

        exp_lv  = '{0, 64, 128, 192, 255};
        exp_cnt = '{0, 128, 256, 384, 512};

        vecs[0] = '{8'hAA, 1'b0, 8'h00, 8'hAA, 1'b0};
        vecs[1] = '{8'h55, 1'b0, 8'hAA, 8'h55, 1'b0};
        vecs[2] = '{8'hAA, 1'b0, 8'h55, 8'hAA, 1'b0};
        vecs[3] = '{8'h55, 1'b0, 8'hAA, 8'h55, 1'b0};
        vecs[4] = '{8'hAA, 1'b0, 8'h55, 8'hAA, 1'b0};

        // Test 1: reset, with FF and fading requested during reset.
        reset_n = 1'b0;
        in_port = 8'hFF;
        fade_en = 1'b1;
        repeat (3) @(negedge clk);
        check("t1_rst_led", {24'd0, led_out}, 32'h00);
        check("t1_rst_busy", {31'd0, busy}, 32'd0);
        check("t1_rst_pwm", {24'd0, dut.pwm_cnt_q}, 32'd0);
        reset_n = 1'b1;
        wait_cyc(1);
        check("t1_pwm_c1", {24'd0, dut.pwm_cnt_q}, 32'd0);
        check("t1_busy_c1", {31'd0, busy}, 32'd0);
        wait_cyc(2);
        check("t1_pwm_c2", {24'd0, dut.pwm_cnt_q}, 32'd1);
        check("t1_busy_c2", {31'd0, busy}, 32'd1);
        wait_cyc(511);
        check("t1_level_511", {24'd0, dut.level_q[0]}, 32'd0);
        check("t1_led_511", {24'd0, led_out}, 32'h00);
        wait_cyc(512);
        check("t1_level0_512", {24'd0, dut.level_q[0]}, 32'd64);
        check("t1_level7_512", {24'd0, dut.level_q[7]}, 32'd64);

        // Test 2: fade up on channel 0.
        do_reset(8'h00);
        wait_cyc(10);
        in_port = 8'h01;
        cnt = 0;
        for (int c = 11; c <= 2560; c++) begin
            wait_cyc(c);
            frame = (c - 1) / 512;
            cnt += int'(led_out[0]);
            if (c == 11)   check("t2_busy_c11", {31'd0, busy}, 32'd0);
            if (c == 12)   check("t2_busy_c12", {31'd0, busy}, 32'd1);
            if (c == 2048) check("t2_busy_2048", {31'd0, busy}, 32'd1);
            if (c == 2049) check("t2_busy_2049", {31'd0, busy}, 32'd0);
            if ((c % 512) == 511 && c < 2048)
                check("t2_level_pre", {24'd0, dut.level_q[0]}, 32'(exp_lv[(c + 1) / 512 - 1]));
            if ((c % 512) == 0 && c <= 2048)
                check("t2_level_step", {24'd0, dut.level_q[0]}, 32'(exp_lv[c / 512]));
            if ((c % 512) == 0) begin
                if (frame >= 1) check("t2_duty", 32'(cnt), 32'(exp_cnt[frame]));
                cnt = 0;
            end
        end
        check("t2_other_ch", {25'd0, led_out[7:1]}, 32'd0);

        // Test 3: fade down, reversal, then full ramp down to 0.
        in_port = 8'h00;
        wait_cyc(3071); check("t3_hold_3071", {24'd0, dut.level_q[0]}, 32'd255);
        wait_cyc(3072); check("t3_dn1", {24'd0, dut.level_q[0]}, 32'd191);
        wait_cyc(3584); check("t3_dn2", {24'd0, dut.level_q[0]}, 32'd127);
        in_port = 8'h01;
        wait_cyc(4096); check("t3_up1", {24'd0, dut.level_q[0]}, 32'd191);
        wait_cyc(4608); check("t3_up_sat", {24'd0, dut.level_q[0]}, 32'd255);
        in_port = 8'h00;
        wait_cyc(6144); check("t3_dn_63", {24'd0, dut.level_q[0]}, 32'd63);
        wait_cyc(6656); check("t3_dn_floor", {24'd0, dut.level_q[0]}, 32'd0);
        check("t3_busy_6656", {31'd0, busy}, 32'd1);
        wait_cyc(6657); check("t3_busy_6657", {31'd0, busy}, 32'd0);
        wait_cyc(7168); check("t3_stable", {24'd0, dut.level_q[0]}, 32'd0);
        check("t3_led_off", {24'd0, led_out}, 32'h00);

        // Test 4: bypass, driven from the vector table.
        fade_en = 1'b0;
        in_port = 8'h00;
        repeat (3) @(negedge clk);
        check("t4_led_init", {24'd0, led_out}, 32'h00);
        for (int i = 0; i < 5; i++) begin
            in_port = vecs[i].in_v;
            fade_en = vecs[i].fade;
            @(negedge clk);
            check("t4_led_d1", {24'd0, led_out}, {24'd0, vecs[i].exp_d1});
            @(negedge clk);
            check("t4_led_d2", {24'd0, led_out}, {24'd0, vecs[i].exp_d2});
            check("t4_busy", {31'd0, busy}, {31'd0, vecs[i].exp_busy});
            @(negedge clk);
        end
        check("t4_snap1", {24'd0, dut.level_q[1]}, 32'd255);
        check("t4_snap0", {24'd0, dut.level_q[0]}, 32'd0);
        fade_en = 1'b1;
        bad_led  = 0;
        bad_busy = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (led_out !== 8'hAA) bad_led++;
            if (busy !== 1'b0)     bad_busy++;
        end
        check("t4_reenable_led", 32'(bad_led), 32'd0);
        check("t4_reenable_busy", 32'(bad_busy), 32'd0);

        // Test 5: target change landing exactly on frame_end.
        f0 = ((cyc / 512) + 2) * 512;
        wait_cyc(f0 - 2);
        in_port = 8'h55;
        wait_cyc(f0 - 1);
        check("t5_pre_l0", {24'd0, dut.level_q[0]}, 32'd0);
        check("t5_pre_l1", {24'd0, dut.level_q[1]}, 32'd255);
        wait_cyc(f0);
        check("t5_new_l0", {24'd0, dut.level_q[0]}, 32'd64);
        check("t5_new_l1", {24'd0, dut.level_q[1]}, 32'd191);
        // The next change reaches in_q only at the frame_end edge itself, so
        // that step still uses the old target.
        wait_cyc(f0 + 511);
        in_port = 8'hAA;
        wait_cyc(f0 + 512);
        check("t5_late_l0", {24'd0, dut.level_q[0]}, 32'd128);
        check("t5_late_l1", {24'd0, dut.level_q[1]}, 32'd127);
        wait_cyc(f0 + 1024);
        check("t5_rev_l0", {24'd0, dut.level_q[0]}, 32'd64);
        check("t5_rev_l1", {24'd0, dut.level_q[1]}, 32'd191);

        // Test 6: reset in the middle of a ramp.
        do_reset(8'h01);
        wait_cyc(1024);
        check("t6_mid_level", {24'd0, dut.level_q[0]}, 32'd128);
        wait_cyc(1100);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_async_level", {24'd0, dut.level_q[0]}, 32'd0);
        check("t6_async_led", {24'd0, led_out}, 32'h00);
        check("t6_async_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_cyc(511);
        check("t6_restart_pre", {24'd0, dut.level_q[0]}, 32'd0);
        wait_cyc(512);
        check("t6_restart_step", {24'd0, dut.level_q[0]}, 32'd64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/led_pwm_fader.md
# led_pwm_fader

Downstream consumer of the LED PIO output port: takes the 8-bit LED pattern written by software and drives the physical LED pins with per-channel PWM. Each channel ramps its brightness linearly toward full-on or full-off, so LED changes fade instead of stepping. It sits between the Qsys LED PIO `out_port` and the board LED pins, in the same clock domain as the PIO.

## Interface
- `CHANNELS`, 8: number of LED channels; one `in_port` bit per channel.
- `TICK_DIV`, 196: clk cycles per PWM step. Legal range is ≥1; a value of 1 produces a tick every cycle.
- `FADE_STEP`, 4: brightness change per PWM frame, range 1..255.
- `clk`, input, 1: system clock. Single clock domain.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `in_port`, input, CHANNELS: target pattern. Bit 1 means on, 0 means off. Synchronous to `clk`.
- `fade_en`, input, 1: 1 selects fading PWM; 0 selects direct bypass.
- `led_out`, output, CHANNELS: registered LED drive, active high.
- `busy`, output, 1: registered; 1 while any channel level differs from its target.

## Operation
- **Input register.** `in_q` <= `in_port` every cycle. All internal logic uses `in_q`, never `in_port` directly.
- **Prescaler.** `presc` counts 0..TICK_DIV-1 and wraps to 0.
  - `tick` is 1 for one cycle when `presc == TICK_DIV-1`.
- **PWM counter.** `pwm_cnt` is 8 bits and increments on `tick`, wrapping 255 -> 0.
  - `frame_end = tick && pwm_cnt == 255`.
  - Frame length is 256*TICK_DIV cycles.
- **Level registers.** Each channel i has an 8-bit `level[i]`. Targets are T=255 when `in_q[i]` is 1 and T=0 otherwise.
  - When `fade_en`=1, on `frame_end`:
    - Ramping up: `level` <= min(level+FADE_STEP, 255), computed 9 bits wide, then saturated.
    - Ramping down: `level` <= max(level-FADE_STEP, 0), with no wrap below 0.
  - Outside `frame_end`, levels hold.
  - When `fade_en`=0, `level[i]` <= T every cycle (snap). Re-enabling fading therefore resumes from the snapped value with no jump.
- **Output compare.** `led_out[i]` next value:
  - When `fade_en`=1: `(level[i] == 255) | (level[i] > pwm_cnt)`. Level 0 gives constantly off; level 255 gives constantly on. A level L in 1..254 gives exactly L on-steps per frame.
  - When `fade_en`=0: `in_q[i]`.
  - The compare uses the current registered `level` and `pwm_cnt`.
- **Busy.** `busy` next value is `fade_en && (any level[i] != T[i])`.
- **Simultaneous events.** If a target flips in the same cycle as `frame_end`, the step applies using `in_q` as sampled in that cycle. The level can change direction at the next frame at the earliest.
- **Stable targets.** No step is taken when the level already equals the target.

## Timing
- **Reset values.** While `reset_n`=0: `led_out`=0, `busy`=0, `in_q`=0, `presc`=0, `pwm_cnt`=0, all `level`=0. Reset asserted mid-ramp aborts the ramp immediately (asynchronous clear).
- **Bypass latency.** `in_port` to `led_out` is 2 cycles (`in_q`, then the output register).
- **Fade latency.** `in_q` change to the first level step happens at the next `frame_end`, up to 256*TICK_DIV cycles later.
  - A full ramp takes ceil(255/FADE_STEP) frames.
- **Busy timing.** `busy` asserts 2 cycles after a target change and deasserts 1 cycle after the final saturating step.
- **Handshakes.** None; the block is free-running after reset release.

## Test plan
All scenarios use TICK_DIV=2 and FADE_STEP=64, giving a 512-cycle frame.
1. **Reset.** Hold `reset_n`=0 with `in_port`=FF and `fade_en`=1 -> `led_out`=00 and `busy`=0. After release, the first `tick` occurs at cycle 2 and the first `frame_end` at cycle 512.
2. **Fade up.** `in_port` 00 -> 01 -> `busy` rises 2 cycles later.
   - `level[0]` steps 64, 128, 192, 255 on the next 4 `frame_end`s.
   - `led_out[0]` is high for 64, 128, 192, then 256 of 256 PWM steps per frame.
   - `busy` clears 1 cycle after the 255 step.
3. **Fade down with reversal.** Start at level 255 and set `in_port`=00 -> level goes 191, then 127.
   - Then set `in_port`=01 -> level goes 191, then 255, with no wrap or underflow.
   - Separately from level 32 with target 0 -> the level reaches 0 in one step.
4. **Bypass.** `fade_en`=0, toggle `in_port` AA <-> 55 -> `led_out` follows exactly 2 cycles later and `busy`=0.
   - Then set `fade_en`=1 with `in_port` unchanged -> `led_out` stays constant (levels are already at 0/255).
5. **Target change at frame_end.** Change `in_port` so that `in_q` updates in the same cycle as `frame_end` -> the step uses the new target in that cycle.
6. **Mid-ramp reset.** Assert `reset_n`=0 while level=128 -> `led_out`=0 and level=0 asynchronously.
   - After release, the ramp restarts from 0 toward the target.
